// File: rtl/param_seg_counter.sv
// Parametrised segmented binary counter.
// SEG_COUNT segments of SEG_WIDTH bits are chained by an exact carry/borrow path,
// so the concatenated value always behaves as one W-bit up/down counter.
// The counter has synchronous clear and load, a wrap or saturate boundary mode,
// and a one-cycle ovf pulse on each boundary event.
module param_seg_counter #(
  parameter int unsigned SEG_WIDTH = 8,
  parameter int unsigned SEG_COUNT = 4,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_,
  input  logic                           en,
  input  logic                           up_dn,
  input  logic                           clr,
  input  logic                           load,
  input  logic [SEG_WIDTH*SEG_COUNT-1:0] load_val,
  output logic [SEG_WIDTH*SEG_COUNT-1:0] q,
  output logic [SEG_COUNT-1:0]           seg_ce,
  output logic                           at_max,
  output logic                           at_min,
  output logic                           ovf
);

  localparam int unsigned W = SEG_WIDTH * SEG_COUNT;
  localparam logic [SEG_WIDTH-1:0] SEG_ONE = SEG_WIDTH'(1);
  localparam logic [W-1:0]         W_ZERO  = W'(0);

  logic [W-1:0]         count_q;
  logic [W-1:0]         count_d;
  logic                 ovf_q;
  logic                 ovf_d;
  logic [SEG_COUNT-1:0] seg_term_s;
  logic [SEG_COUNT-1:0] seg_ce_s;
  logic [W-1:0]         step_s;
  logic                 boundary_s;

  assign q      = count_q;
  assign ovf    = ovf_q;
  assign seg_ce = seg_ce_s;
  assign at_max = &count_q;
  assign at_min = ~|count_q;

  // A count attempt that would cross the all-ones / all-zeros boundary.
  assign boundary_s = en & (up_dn ? at_max : at_min);

  // Terminal detect per segment: all-ones when counting up, all-zeros when counting down.
  always_comb begin
    seg_term_s = '0;
    for (int k = 0; k < int'(SEG_COUNT); k++) begin
      if (up_dn) begin
        seg_term_s[k] = &count_q[k*SEG_WIDTH +: SEG_WIDTH];
      end else begin
        seg_term_s[k] = ~|count_q[k*SEG_WIDTH +: SEG_WIDTH];
      end
    end
  end

  // Ripple enable chain; clear and load suppress every step enable.
  always_comb begin
    logic [SEG_COUNT-1:0] ce_v;
    ce_v    = '0;
    ce_v[0] = en & ~clr & ~load;
    for (int k = 1; k < int'(SEG_COUNT); k++) begin
      ce_v[k] = ce_v[k-1] & seg_term_s[k-1];
    end
    seg_ce_s = ce_v;
  end

  // Step each enabled segment by +/-1 modulo its width; other segments hold.
  always_comb begin
    step_s = count_q;
    for (int k = 0; k < int'(SEG_COUNT); k++) begin
      if (seg_ce_s[k]) begin
        if (up_dn) begin
          step_s[k*SEG_WIDTH +: SEG_WIDTH] = count_q[k*SEG_WIDTH +: SEG_WIDTH] + SEG_ONE;
        end else begin
          step_s[k*SEG_WIDTH +: SEG_WIDTH] = count_q[k*SEG_WIDTH +: SEG_WIDTH] - SEG_ONE;
        end
      end else begin
        step_s[k*SEG_WIDTH +: SEG_WIDTH] = count_q[k*SEG_WIDTH +: SEG_WIDTH];
      end
    end
  end

  // Next count and ovf with priority clr > load > boundary step > ordinary step > hold.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (clr) begin
      count_d = W_ZERO;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_val;
      ovf_d   = 1'b0;
    end else if (boundary_s) begin
      // Saturate holds at the boundary and keeps re-pulsing ovf; wrap takes the step.
      count_d = SATURATE ? count_q : step_s;
      ovf_d   = 1'b1;
    end else if (en) begin
      count_d = step_s;
      ovf_d   = 1'b0;
    end else begin
      count_d = count_q;
      ovf_d   = 1'b0;
    end
  end

  // Count and ovf registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count_q <= W_ZERO;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_param_seg_counter.sv
// Bench for param_seg_counter: a wrapping 8x4 instance (A) and a saturating 4x3 instance (B).
// A reference model pushes the expected q/ovf for each edge into a queue; the
// queue entry is popped and compared after the edge.
module tb_param_seg_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_;

  // Instance A: SEG_WIDTH=8, SEG_COUNT=4, wrap
  logic        a_en, a_up, a_clr, a_load;
  logic [31:0] a_lv, a_q;
  logic [3:0]  a_ce;
  logic        a_max, a_min, a_ovf;

  // Instance B: SEG_WIDTH=4, SEG_COUNT=3, saturate
  logic        b_en, b_up, b_clr, b_load;
  logic [11:0] b_lv, b_q;
  logic [2:0]  b_ce;
  logic        b_max, b_min, b_ovf;

  param_seg_counter #(.SEG_WIDTH(8), .SEG_COUNT(4), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst_(rst_), .en(a_en), .up_dn(a_up), .clr(a_clr), .load(a_load),
    .load_val(a_lv), .q(a_q), .seg_ce(a_ce), .at_max(a_max), .at_min(a_min), .ovf(a_ovf)
  );

  param_seg_counter #(.SEG_WIDTH(4), .SEG_COUNT(3), .SATURATE(1'b1)) u_b (
    .clk(clk), .rst_(rst_), .en(b_en), .up_dn(b_up), .clr(b_clr), .load(b_load),
    .load_val(b_lv), .q(b_q), .seg_ce(b_ce), .at_max(b_max), .at_min(b_min), .ovf(b_ovf)
  );

  typedef struct packed {
    logic [31:0] q;
    logic        ovf;
  } exp_t;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  logic [31:0] ma_q;
  logic        ma_ovf;
  logic [11:0] mb_q;
  logic        mb_ovf;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: advance both models by one edge from the current inputs.
  task automatic model_edge();
    if (a_clr) begin
      ma_q = 32'd0; ma_ovf = 1'b0;
    end else if (a_load) begin
      ma_q = a_lv; ma_ovf = 1'b0;
    end else if (a_en && a_up) begin
      ma_ovf = (ma_q == 32'hFFFF_FFFF); ma_q = ma_q + 32'd1;
    end else if (a_en) begin
      ma_ovf = (ma_q == 32'd0); ma_q = ma_q - 32'd1;
    end else begin
      ma_ovf = 1'b0;
    end

    if (b_clr) begin
      mb_q = 12'd0; mb_ovf = 1'b0;
    end else if (b_load) begin
      mb_q = b_lv; mb_ovf = 1'b0;
    end else if (b_en && b_up) begin
      mb_ovf = (mb_q == 12'hFFF);
      if (!mb_ovf) mb_q = mb_q + 12'd1;
    end else if (b_en) begin
      mb_ovf = (mb_q == 12'd0);
      if (!mb_ovf) mb_q = mb_q - 12'd1;
    end else begin
      mb_ovf = 1'b0;
    end
    sb_a.push_back('{q: ma_q, ovf: ma_ovf});
    sb_b.push_back('{q: 32'(mb_q), ovf: mb_ovf});
  endtask

  // One clock: push expectations, wait for the edge, pop and compare both instances.
  task automatic step();
    exp_t ea;
    exp_t eb;
    model_edge();
    @(posedge clk);
    #1;
    ea = sb_a.pop_front();
    eb = sb_b.pop_front();
    check_val("a_q",   a_q, ea.q);
    check_val("a_ovf", 32'(a_ovf), 32'(ea.ovf));
    check_val("a_min", 32'(a_min), 32'(ea.q == 32'd0));
    check_val("a_max", 32'(a_max), 32'(ea.q == 32'hFFFF_FFFF));
    check_val("b_q",   32'(b_q), eb.q);
    check_val("b_ovf", 32'(b_ovf), 32'(eb.ovf));
  endtask

  initial begin
    rst_ = 1'b1;
    a_en = 1'b0; a_up = 1'b1; a_clr = 1'b0; a_load = 1'b0; a_lv = 32'd0;
    b_en = 1'b0; b_up = 1'b1; b_clr = 1'b0; b_load = 1'b0; b_lv = 12'd0;
    ma_q = 32'd0; ma_ovf = 1'b0; mb_q = 12'd0; mb_ovf = 1'b0;

    // Reset and idle
    #2 rst_ = 1'b0;
    #10;
    check_val("rst_a_q",   a_q, 32'd0);
    check_val("rst_a_ovf", 32'(a_ovf), 32'd0);
    check_val("rst_a_min", 32'(a_min), 32'd1);
    check_val("rst_b_q",   32'(b_q), 32'd0);
    rst_ = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Segment carry
    a_load = 1'b1; a_lv = 32'h0000_00FE; step();
    a_load = 1'b0; a_en = 1'b1; a_up = 1'b1; step();
    check_val("carry_q1", a_q, 32'h0000_00FF);
    check_val("carry_ce", 32'(a_ce), 32'h3);
    step();
    check_val("carry_q2", a_q, 32'h0000_0100);
    step();
    check_val("carry_q3", a_q, 32'h0000_0101);

    // Full wrap up then down
    a_en = 1'b0; a_load = 1'b1; a_lv = 32'hFFFF_FFFF; step();
    check_val("ce_idle", 32'(a_ce), 32'h0);
    a_load = 1'b0; a_en = 1'b1; a_up = 1'b1; step();
    check_val("wrap_up_q", a_q, 32'h0000_0000);
    check_val("wrap_up_ovf", 32'(a_ovf), 32'd1);
    a_up = 1'b0; step();
    check_val("wrap_dn_q", a_q, 32'hFFFF_FFFF);
    check_val("wrap_dn_ovf", 32'(a_ovf), 32'd1);
    a_en = 1'b0; step();
    check_val("wrap_ovf_drop", 32'(a_ovf), 32'd0);

    // Priority clr > load > en
    a_clr = 1'b1; a_load = 1'b1; a_lv = 32'h1234_5678; a_en = 1'b1; a_up = 1'b1;
    #1 check_val("ce_forced0", 32'(a_ce), 32'h0);
    step();
    check_val("prio_clr", a_q, 32'd0);
    a_clr = 1'b0; step();
    check_val("prio_load", a_q, 32'h1234_5678);
    a_load = 1'b0; a_up = 1'b0; step();
    check_val("prio_dn", a_q, 32'h1234_5677);
    a_en = 1'b0;

    // Saturate on B
    b_load = 1'b1; b_lv = 12'hFFE; step();
    b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_val("sat_q", 32'(b_q), 32'h0FFF);
    check_val("sat_ovf", 32'(b_ovf), 32'd1);
    b_up = 1'b0; step();
    check_val("sat_dn_q", 32'(b_q), 32'h0FFE);
    check_val("sat_dn_ovf", 32'(b_ovf), 32'd0);
    b_load = 1'b1; b_lv = 12'h000; step();
    b_load = 1'b0; step();
    check_val("sat_min_q", 32'(b_q), 32'h0);
    check_val("sat_min_ovf", 32'(b_ovf), 32'd1);

    // Async reset mid-count; B is held at its boundary so its ovf is high
    b_up = 1'b1; b_load = 1'b1; b_lv = 12'hFFF; step();
    b_load = 1'b0; step();
    a_load = 1'b1; a_lv = 32'h0000_ABCC; step();
    a_load = 1'b0; a_en = 1'b1; a_up = 1'b1; step();
    check_val("pre_rst_q", a_q, 32'h0000_ABCD);
    #2 rst_ = 1'b0;
    #1;
    check_val("arst_a_q",   a_q, 32'd0);
    check_val("arst_a_ovf", 32'(a_ovf), 32'd0);
    check_val("arst_b_q",   32'(b_q), 32'd0);
    check_val("arst_b_ovf", 32'(b_ovf), 32'd0);
    ma_q = 32'd0; ma_ovf = 1'b0; mb_q = 12'd0; mb_ovf = 1'b0;
    rst_ = 1'b1;
    step();
    check_val("restart_q", a_q, 32'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
